osnt_oq_rr_scheduler: RTL and testbench



---
 rtl/osnt_oq_rr_scheduler_pkg.sv | 25 ++
 rtl/osnt_rr_pick.sv | 29 ++
 rtl/osnt_oq_rr_scheduler.sv | 101 ++++++++++
 tb/tb_osnt_oq_rr_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osnt_oq_rr_scheduler_pkg.sv
// Shared definitions for the OSNT output-queue round-robin scheduler: state encoding,
// grant-width helper and flattened-bus slice helper.
package osnt_oq_rr_scheduler_pkg;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StSend = 1'b1
   } state_e;

   // Ceiling log2; callers guarantee n >= 2 so the result is never zero.
   function automatic int unsigned log2c(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // Low bit of slice idx in a flattened bus of width-bit lanes.
   function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
      return idx * width;
   endfunction

endpackage

// File: rtl/osnt_rr_pick.sv
// Combinational rotating-priority encoder: first eligible index strictly after last_served,
// wrapping modulo NumQueues (last_served itself is checked last).
module osnt_rr_pick #(
   parameter int unsigned NumQueues = 4,
   parameter int unsigned IdxW      = 2
) (
   input  logic [NumQueues-1:0] eligible_i,
   input  logic [IdxW-1:0]      last_served_i,
   output logic                 found_o,
   output logic [IdxW-1:0]      index_o
);

   logic [IdxW-1:0] cand;

   always_comb begin
      found_o = 1'b0;
      index_o = '0;
      cand    = '0;
      // Walk from the farthest candidate to the nearest so the nearest eligible one wins.
      for (int unsigned off = NumQueues; off >= 1; off--) begin
         cand = IdxW'((32'(last_served_i) + off) % NumQueues);
         if (eligible_i[cand]) begin
            found_o = 1'b1;
            index_o = cand;
         end
      end
   end

endmodule

// File: rtl/osnt_oq_rr_scheduler.sv
// Packet-granular round-robin merge of NUM_QUEUES AXI4-Stream queues onto one master port.
// Select is registered; data, valid and ready pass through combinationally while sending.
module osnt_oq_rr_scheduler
   import osnt_oq_rr_scheduler_pkg::*;
#(
   parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
   parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
   parameter int unsigned NUM_QUEUES           = 4,
   localparam int unsigned IdxW                = log2c(NUM_QUEUES),
   localparam int unsigned StrbW               = C_M_AXIS_DATA_WIDTH / 8
) (
   input  logic                                       axi_aclk,
   input  logic                                       axi_reset,
   input  logic [NUM_QUEUES-1:0]                      queue_enable,
   input  logic [NUM_QUEUES*C_M_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
   input  logic [NUM_QUEUES*StrbW-1:0]                s_axis_tstrb,
   input  logic [NUM_QUEUES*C_M_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
   input  logic [NUM_QUEUES-1:0]                      s_axis_tvalid,
   input  logic [NUM_QUEUES-1:0]                      s_axis_tlast,
   output logic [NUM_QUEUES-1:0]                      s_axis_tready,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]             m_axis_tdata,
   output logic [StrbW-1:0]                           m_axis_tstrb,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]            m_axis_tuser,
   output logic                                       m_axis_tvalid,
   output logic                                       m_axis_tlast,
   input  logic                                       m_axis_tready,
   output logic [IdxW-1:0]                            cur_queue
);

   state_e                state_q, state_d;
   logic [IdxW-1:0]       grant_q, grant_d;
   logic [IdxW-1:0]       last_served_q, last_served_d;
   logic [NUM_QUEUES-1:0] eligible;
   logic                  pick_found;
   logic [IdxW-1:0]       pick_idx;

   assign eligible  = s_axis_tvalid & queue_enable;
   assign cur_queue = grant_q;

   osnt_rr_pick #(
      .NumQueues(NUM_QUEUES),
      .IdxW     (IdxW)
   ) u_pick (
      .eligible_i   (eligible),
      .last_served_i(last_served_q),
      .found_o      (pick_found),
      .index_o      (pick_idx)
   );

   always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
         state_q       <= StIdle;
         grant_q       <= '0;
         last_served_q <= IdxW'(NUM_QUEUES - 1);
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         last_served_q <= last_served_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_served_d = last_served_q;
      unique case (state_q)
         StIdle: begin
            if (pick_found) begin
               grant_d = pick_idx;
               state_d = StSend;
            end
         end
         StSend: begin
            // Enable is ignored here: a granted packet always runs to tlast.
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
               last_served_d = grant_q;
               state_d       = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      m_axis_tdata = '0;
      m_axis_tstrb = '0;
      m_axis_tuser = '0;
      for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
         if (grant_q == IdxW'(q)) begin
            m_axis_tdata = s_axis_tdata[slice_lo(q, C_M_AXIS_DATA_WIDTH) +: C_M_AXIS_DATA_WIDTH];
            m_axis_tstrb = s_axis_tstrb[slice_lo(q, StrbW) +: StrbW];
            m_axis_tuser = s_axis_tuser[slice_lo(q, C_M_AXIS_TUSER_WIDTH) +: C_M_AXIS_TUSER_WIDTH];
         end
      end
      m_axis_tvalid = (state_q == StSend) & s_axis_tvalid[grant_q];
      m_axis_tlast  = (state_q == StSend) & s_axis_tlast[grant_q];
      s_axis_tready = '0;
      if (state_q == StSend) s_axis_tready[grant_q] = m_axis_tready;
   end

endmodule

// File: tb/tb_osnt_oq_rr_scheduler.sv
// Bench for osnt_oq_rr_scheduler: packet-level sources, an ownership-based reference model,
// an arbitration vector table, directed corner sequences and a randomized soak.
module tb_osnt_oq_rr_scheduler;

   localparam int NQ = 4;
   localparam int DW = 32;
   localparam int UW = 8;
   localparam int SW = DW / 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [NQ-1:0]     queue_enable;
   logic [NQ*DW-1:0]  s_tdata;
   logic [NQ*SW-1:0]  s_tstrb;
   logic [NQ*UW-1:0]  s_tuser;
   logic [NQ-1:0]     s_tvalid, s_tlast, s_tready;
   logic [DW-1:0]     m_tdata;
   logic [SW-1:0]     m_tstrb;
   logic [UW-1:0]     m_tuser;
   logic              m_tvalid, m_tlast, m_tready;
   logic [1:0]        cur_queue;

   always #5 clk = ~clk;

   osnt_oq_rr_scheduler #(
      .C_M_AXIS_DATA_WIDTH (DW),
      .C_M_AXIS_TUSER_WIDTH(UW),
      .NUM_QUEUES          (NQ)
   ) dut (
      .axi_aclk     (clk),
      .axi_reset    (rst),
      .queue_enable (queue_enable),
      .s_axis_tdata (s_tdata),
      .s_axis_tstrb (s_tstrb),
      .s_axis_tuser (s_tuser),
      .s_axis_tvalid(s_tvalid),
      .s_axis_tlast (s_tlast),
      .s_axis_tready(s_tready),
      .m_axis_tdata (m_tdata),
      .m_axis_tstrb (m_tstrb),
      .m_axis_tuser (m_tuser),
      .m_axis_tvalid(m_tvalid),
      .m_axis_tlast (m_tlast),
      .m_axis_tready(m_tready),
      .cur_queue    (cur_queue)
   );

   int total;
   int bad;

   // Source queues: packet length, current beat, packet number, packets left, valid hold-off.
   int len[NQ], beat[NQ], pkt[NQ], quota[NQ], hold[NQ], delivered[NQ];
   int cfg_len, cfg_stall, cfg_gap, cfg_tready, cfg_en_rand;

   // Reference model: which queue owns the master port (-1 = none) and who was served last.
   int own, last;
   bit fresh;
   bit dut_in_pkt;
   int dstarts[$];

   typedef struct {
      int         prime;
      logic [3:0] en;
      logic [3:0] vld;
      int         exp;
   } arb_vec_t;

   arb_vec_t tbl[11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] enc(input int q, input int p, input int b);
      return {8'(q), 8'(p), 8'(b), 8'h5A};
   endfunction

   function automatic int new_len();
      return (cfg_len != 0) ? cfg_len : int'($urandom_range(1, 5));
   endfunction

   function automatic int rr_pick(input logic [NQ-1:0] elig, input int from);
      for (int k = 1; k <= NQ; k++) begin
         int c;
         c = (from + k) % NQ;
         if (elig[c]) return c;
      end
      return -1;
   endfunction

   task automatic drive_src();
      for (int q = 0; q < NQ; q++) begin
         s_tvalid[q]          = (quota[q] > 0) && (hold[q] == 0);
         s_tlast[q]           = (beat[q] == len[q] - 1);
         s_tdata[q*DW +: DW]  = enc(q, pkt[q], beat[q]);
         s_tuser[q*UW +: UW]  = {4'(q), 4'(pkt[q])};
         s_tstrb[q*SW +: SW]  = SW'(len[q]);
      end
   endtask

   task automatic src_init(input logic [NQ-1:0] mask, input int pkts);
      for (int q = 0; q < NQ; q++) begin
         quota[q]     = mask[q] ? pkts : 0;
         beat[q]      = 0;
         pkt[q]       = 0;
         len[q]       = new_len();
         hold[q]      = 0;
         delivered[q] = 0;
      end
      drive_src();
   endtask

   task automatic model_reset();
      own        = -1;
      last       = NQ - 1;
      fresh      = 1'b1;
      dut_in_pkt = 1'b0;
      dstarts.delete();
   endtask

   task automatic hard_reset();
      cfg_tready  = 0;
      cfg_stall   = 0;
      cfg_gap     = 0;
      cfg_en_rand = 0;
      m_tready    = 1'b1;
      queue_enable = '1;
      src_init('0, 0);
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      model_reset();
      rst = 1'b0;
   endtask

   // One clock: compare at the falling edge, then update sources just after the rising edge.
   task automatic run_cycle();
      logic [NQ-1:0] hs;
      logic [NQ-1:0] exp_tr;
      logic          exp_tv;
      @(negedge clk);
      exp_tv = (own >= 0) ? s_tvalid[own] : 1'b0;
      exp_tr = '0;
      if (own >= 0 && m_tready) exp_tr[own] = 1'b1;
      check("m_tvalid", 64'(m_tvalid), 64'(exp_tv));
      check("s_tready", 64'(s_tready), 64'(exp_tr));
      if (own < 0 && fresh) check("reset_cur_queue", 64'(cur_queue), 64'd0);
      if (own >= 0) begin
         check("cur_queue", 64'(cur_queue), 64'(own));
         if (exp_tv) begin
            check("m_tdata", 64'(m_tdata), 64'(s_tdata[own*DW +: DW]));
            check("m_tlast", 64'(m_tlast), 64'(s_tlast[own]));
            check("m_tuser", 64'(m_tuser), 64'(s_tuser[own*UW +: UW]));
            check("m_tstrb", 64'(m_tstrb), 64'(s_tstrb[own*SW +: SW]));
         end
      end
      if (m_tvalid && !dut_in_pkt) begin
         dstarts.push_back(int'(cur_queue));
         dut_in_pkt = 1'b1;
      end
      if (m_tvalid && m_tready && m_tlast) dut_in_pkt = 1'b0;
      hs = s_tvalid & s_tready;
      if (rst) begin
         model_reset();
      end else if (own < 0) begin
         own = rr_pick(s_tvalid & queue_enable, last);
         if (own >= 0) fresh = 1'b0;
      end else if (s_tvalid[own] && m_tready && s_tlast[own]) begin
         last = own;
         own  = -1;
      end
      @(posedge clk);
      #1;
      for (int q = 0; q < NQ; q++) begin
         if (hold[q] > 0) hold[q]--;
         if (hs[q]) begin
            delivered[q]++;
            if (beat[q] == len[q] - 1) begin
               beat[q] = 0;
               pkt[q]++;
               len[q] = new_len();
               quota[q]--;
               if (cfg_gap != 0) hold[q] = $urandom_range(0, 3);
            end else begin
               beat[q]++;
               if (cfg_stall != 0) hold[q] = $urandom_range(0, 2);
            end
         end
      end
      case (cfg_tready)
         1:       m_tready = ~m_tready;
         2:       m_tready = ($urandom_range(0, 3) != 0);
         default: m_tready = 1'b1;
      endcase
      if (cfg_en_rand != 0 && $urandom_range(0, 19) == 0) queue_enable = NQ'($urandom);
      drive_src();
   endtask

   task automatic check_starts(input string name, input int exp[$]);
      check({name, "_count"}, 64'(dstarts.size()), 64'(exp.size()));
      for (int i = 0; i < exp.size() && i < dstarts.size(); i++) begin
         check($sformatf("%s_%0d", name, i), 64'(dstarts[i]), 64'(exp[i]));
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int got;
      total = 0;
      bad   = 0;
      cfg_len = 1;
      tbl[0]  = '{-1, 4'b1111, 4'b1111, 0};
      tbl[1]  = '{-1, 4'b1111, 4'b0110, 1};
      tbl[2]  = '{ 0, 4'b1111, 4'b1111, 1};
      tbl[3]  = '{ 3, 4'b1111, 4'b1110, 1};
      tbl[4]  = '{ 2, 4'b1111, 4'b0111, 0};
      tbl[5]  = '{ 1, 4'b1011, 4'b1100, 3};
      tbl[6]  = '{ 1, 4'b0111, 4'b1001, 0};
      tbl[7]  = '{ 3, 4'b1110, 4'b1111, 1};
      tbl[8]  = '{ 2, 4'b1111, 4'b0100, 2};
      tbl[9]  = '{-1, 4'b0000, 4'b1111, -1};
      tbl[10] = '{ 3, 4'b1111, 4'b1000, 3};

      // Queue 1 alone, one 3-beat packet.
      cfg_len = 3;
      hard_reset();
      src_init(4'b0010, 1);
      repeat (8) run_cycle();
      check_starts("single", '{1});
      check("single_beats", 64'(delivered[1]), 64'd3);

      // All queues busy with 2-beat packets: strict rotation, one bubble each.
      cfg_len = 2;
      hard_reset();
      src_init(4'b1111, 2);
      repeat (30) run_cycle();
      check_starts("rotate", '{0, 1, 2, 3, 0, 1, 2, 3});

      // Downstream ready toggling during a 4-beat packet from queue 2.
      cfg_len = 4;
      hard_reset();
      cfg_tready = 1;
      src_init(4'b0100, 1);
      repeat (14) run_cycle();
      check_starts("toggle", '{2});
      check("toggle_beats", 64'(delivered[2]), 64'd4);

      // Disabled queue 2 is skipped; disabling queue 3 mid-packet does not abort it.
      cfg_len = 3;
      hard_reset();
      src_init(4'b0010, 1);
      repeat (6) run_cycle();
      queue_enable = 4'b1011;
      quota[2] = 1;
      quota[3] = 1;
      drive_src();
      for (int i = 0; i < 10 && delivered[3] < 1; i++) run_cycle();
      queue_enable[3] = 1'b0;
      repeat (8) run_cycle();
      check_starts("enable", '{1, 3});
      check("enable_q3_beats", 64'(delivered[3]), 64'd3);
      check("enable_q2_beats", 64'(delivered[2]), 64'd0);

      // Reset while beat 2 of a 5-beat packet is on the bus.
      cfg_len = 5;
      hard_reset();
      src_init(4'b0001, 1);
      for (int i = 0; i < 10 && delivered[0] < 1; i++) run_cycle();
      check("rst_reached_beat2", 64'(delivered[0]), 64'd1);
      rst = 1'b1;
      run_cycle();
      rst = 1'b0;
      cfg_len = 1;
      src_init(4'b1111, 1);
      repeat (10) run_cycle();
      check_starts("post_reset", '{0, 1, 2, 3});

      // Queue 0 stalls mid-packet; queue 1 waits for its tlast.
      cfg_len = 4;
      hard_reset();
      src_init(4'b0011, 1);
      for (int i = 0; i < 10 && delivered[0] < 1; i++) run_cycle();
      hold[0] = 3;
      drive_src();
      repeat (16) run_cycle();
      check_starts("stall", '{0, 1});
      check("stall_q0_beats", 64'(delivered[0]), 64'd4);
      check("stall_q1_beats", 64'(delivered[1]), 64'd4);

      // Arbitration table.
      foreach (tbl[i]) begin
         cfg_len = 1;
         hard_reset();
         if (tbl[i].prime >= 0) begin
            src_init(NQ'(1 << tbl[i].prime), 1);
            repeat (4) run_cycle();
         end
         dstarts.delete();
         queue_enable = tbl[i].en;
         src_init(tbl[i].vld, 1);
         repeat (3) run_cycle();
         got = (dstarts.size() > 0) ? dstarts[0] : -1;
         check($sformatf("arb_%0d", i), 64'(got), 64'(tbl[i].exp));
      end

      // Randomized soak against the model.
      cfg_len = 0;
      hard_reset();
      cfg_stall   = 1;
      cfg_gap     = 1;
      cfg_tready  = 2;
      cfg_en_rand = 1;
      src_init('1, 1000000);
      repeat (3000) run_cycle();
      check("rand_progress", 64'(dstarts.size() > 50), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
